// File: rtl/dot_product_inverse.sv
// dot_product_inverse: builds vector_b so popcount(vector_a & vector_b) hits a target, one bit per clock
module dot_product_inverse #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] vector_a,
  input  logic [CW-1:0]    target,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] vector_b,
  output logic             ok
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    rem_next;
  logic [IW-1:0]    idx;
  logic             take;
  logic             last;
  assign busy = state != IDLE;
  assign done = state == DONE_ST;
  // select the current bit only while the target is not yet met, so remaining never underflows
  always_comb begin
    take     = a_reg[idx] && remaining != '0;
    rem_next = remaining - CW'(take);
    last     = idx == IW'(WIDTH - 1);
  end
  // fixed-latency scan: every bit is visited even after the target is met
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      remaining <= '0;
      idx       <= '0;
      vector_b  <= '0;
      ok        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= SCAN;
          a_reg     <= vector_a;
          remaining <= target;
          idx       <= '0;
          vector_b  <= '0;
          ok        <= 1'b0;
        end
        SCAN: begin
          if (take) vector_b[idx] <= 1'b1;
          remaining <= rem_next;
          idx       <= idx + IW'(1);
          if (last) begin
            state <= DONE_ST;
            ok    <= rem_next == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_inverse.sv
// tb_dot_product_inverse: directed vector table, hand-written corner sequences and a random invariant loop
module tb_dot_product_inverse;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vector_a = '0;
  logic [5:0]  target = '0;
  logic        busy, done, ok;
  logic [31:0] vector_b;
  int n_cmp = 0;
  int n_err = 0;

  dot_product_inverse #(.WIDTH(32), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vector_a(vector_a), .target(target),
    .busy(busy), .done(done), .vector_b(vector_b), .ok(ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  t;
    logic [31:0] exp_b;
    logic        exp_ok;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // start at the next negedge, then watch busy/done at each negedge until idle
  task automatic run_op(input logic [31:0] a, input logic [5:0] t,
                        output logic [31:0] b, output logic o,
                        output int busy_cnt, output int done_idx, output int done_cnt);
    int i;
    busy_cnt = 0;
    done_idx = -1;
    done_cnt = 0;
    @(negedge clk);
    vector_a = a;
    target = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vector_a = ~a;
    target = ~t;
    for (i = 1; i < 100; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
      end
      if (!busy) break;
      @(negedge clk);
    end
    if (i >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: busy still %b after 100 cycles, required 0", busy);
    end
    b = vector_b;
    o = ok;
  endtask

  vec_t tbl[10];

  initial begin
    logic [31:0] b;
    logic        o;
    int bc, di, dc, pc, lim;
    logic [31:0] a;
    logic [5:0]  t;

    tbl[0] = '{32'hFFFFFFFF, 6'd5,  32'h0000001F, 1'b1};
    tbl[1] = '{32'hA5A5A5A5, 6'd3,  32'h00000025, 1'b1};
    tbl[2] = '{32'hA5A5A5A5, 6'd16, 32'hA5A5A5A5, 1'b1};
    tbl[3] = '{32'hA5A5A5A5, 6'd17, 32'hA5A5A5A5, 1'b0};
    tbl[4] = '{32'h12345678, 6'd0,  32'h00000000, 1'b1};
    tbl[5] = '{32'h00000000, 6'd1,  32'h00000000, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 6'd32, 32'hFFFFFFFF, 1'b1};
    tbl[7] = '{32'hFFFFFFFF, 6'd63, 32'hFFFFFFFF, 1'b0};
    tbl[8] = '{32'h0000F000, 6'd2,  32'h00003000, 1'b1};
    tbl[9] = '{32'h80000001, 6'd2,  32'h80000001, 1'b1};

    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_vector_b", vector_b, 32'd0);
    chk("reset_ok", {31'd0, ok}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      run_op(tbl[k].a, tbl[k].t, b, o, bc, di, dc);
      chk($sformatf("tbl%0d_vector_b", k), b, tbl[k].exp_b);
      chk($sformatf("tbl%0d_ok", k), {31'd0, o}, {31'd0, tbl[k].exp_ok});
      chk($sformatf("tbl%0d_busy_cycles", k), bc, 33);
      chk($sformatf("tbl%0d_done_cycle", k), di, 33);
      chk($sformatf("tbl%0d_done_count", k), dc, 1);
    end

    // starts during the scan and in the DONE cycle are ignored; a start in the first idle cycle is taken
    @(negedge clk);
    vector_a = 32'h0000F000;
    target = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    di = -1;
    for (int i = 1; i < 40; i++) begin
      if (i == 10) begin
        start = 1'b1;
        vector_a = 32'hFFFFFFFF;
        target = 6'd31;
      end
      if (i == 11) start = 1'b0;
      if (done) begin
        di = i;
        start = 1'b1;
        vector_a = 32'hFFFFFFFF;
        target = 6'd20;
        break;
      end
      @(negedge clk);
    end
    chk("ign_done_cycle", di, 33);
    @(negedge clk);
    chk("ign_idle_after_done", {31'd0, busy}, 32'd0);
    chk("ign_vector_b", vector_b, 32'h00003000);
    chk("ign_ok", {31'd0, ok}, 32'd1);
    vector_a = 32'h000000FF;
    target = 6'd3;
    @(negedge clk);
    start = 1'b0;
    chk("back2back_accepted", {31'd0, busy}, 32'd1);
    di = -1;
    for (int i = 1; i < 40; i++) begin
      if (done) begin
        di = i;
        break;
      end
      @(negedge clk);
    end
    chk("back2back_done_cycle", di, 33);
    chk("back2back_vector_b", vector_b, 32'h00000007);
    chk("back2back_ok", {31'd0, ok}, 32'd1);

    // asynchronous reset mid-scan abandons the operation
    @(negedge clk);
    @(negedge clk);
    vector_a = 32'hFFFFFFFF;
    target = 6'd32;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midscan_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_vector_b", vector_b, 32'd0);
    chk("arst_ok", {31'd0, ok}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    chk("arst_no_done_after_release", dc, 0);
    run_op(32'h0000F0F0, 6'd4, b, o, bc, di, dc);
    chk("post_reset_vector_b", b, 32'h000000F0);
    chk("post_reset_ok", {31'd0, o}, 32'd1);
    chk("post_reset_done_cycle", di, 33);

    // random operands checked against the dot-product invariants
    for (int k = 0; k < 1000; k++) begin
      a = (k % 3 == 0) ? ($urandom & $urandom) : $urandom;
      t = 6'($urandom_range(0, 63));
      run_op(a, t, b, o, bc, di, dc);
      pc = $countones(a);
      lim = (int'(t) < pc) ? int'(t) : pc;
      chk($sformatf("rnd%0d_dot", k), $countones(a & b), lim);
      chk($sformatf("rnd%0d_subset", k), b & ~a, 32'd0);
      chk($sformatf("rnd%0d_ok", k), {31'd0, o}, {31'd0, (int'(t) <= pc)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
